// File: rtl/c2c_pkg.sv
// Shared definitions for the Aurora chip-to-chip link controllers (master and slave side).
package c2c_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_PB_HOLD = 3'd1,
    ST_WAIT_CH = 3'd2,
    ST_UP      = 3'd3,
    ST_DOWN    = 3'd4
  } c2c_state_e;

  localparam int unsigned C2C_PMA_INIT_CYCLES = 1000;
  localparam int unsigned C2C_RESET_PB_HOLD   = 100;
  localparam int unsigned C2C_CHANNEL_TIMEOUT = 1048576;
  localparam int unsigned C2C_DROP_FILTER     = 16;
  localparam int unsigned C2C_CNT_W           = 8;

  function automatic int unsigned c2c_max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/c2c_sync2.sv
// Two-flop synchroniser for a single level signal; both flops clear to 0 on reset.
module c2c_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/c2c_master_link_ctrl.sv
// Master-side Aurora C2C bring-up/recovery sequencer: pma_init -> reset_pb -> channel_up,
// then holds link_up until a filtered channel drop, a link error or a software reinit.
module c2c_master_link_ctrl
  import c2c_pkg::*;
#(
  parameter int unsigned PMA_INIT_CYCLES = C2C_PMA_INIT_CYCLES,
  parameter int unsigned RESET_PB_HOLD   = C2C_RESET_PB_HOLD,
  parameter int unsigned CHANNEL_TIMEOUT = C2C_CHANNEL_TIMEOUT,
  parameter int unsigned DROP_FILTER     = C2C_DROP_FILTER,
  parameter int unsigned CNT_W           = C2C_CNT_W
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             channel_up_async,
  input  logic             c2c_link_error,
  input  logic             reinit_req,
  input  logic             clear_counts,
  output logic             aurora_pma_init,
  output logic             aurora_reset_pb,
  output logic             link_up,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned TMR_W =
    $clog2(c2c_max3(PMA_INIT_CYCLES, RESET_PB_HOLD, CHANNEL_TIMEOUT)) + 1;
  localparam int unsigned FLT_W = $clog2(DROP_FILTER) + 1;

  localparam logic [TMR_W-1:0] PMA_LAST = TMR_W'(PMA_INIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] PB_LAST  = TMR_W'(RESET_PB_HOLD - 1);
  localparam logic [TMR_W-1:0] CTO_LAST = TMR_W'(CHANNEL_TIMEOUT - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(DROP_FILTER - 1);

  c2c_state_e       state_q;
  logic [TMR_W-1:0] timer_q;
  logic [FLT_W-1:0] filt_q;
  logic             pma_init_q;
  logic             reset_pb_q;
  logic             link_up_q;
  logic [CNT_W-1:0] retry_q;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] retry_inc;
  logic [CNT_W-1:0] drop_inc;
  logic             ch_up;

  c2c_sync2 u_ch_up_sync (
    .clk_i  (aclk),
    .rst_ni (aresetn),
    .d_i    (channel_up_async),
    .q_o    (ch_up)
  );

  assign retry_inc = (retry_q == '1) ? retry_q : retry_q + CNT_W'(1);
  assign drop_inc  = (drop_q == '1) ? drop_q : drop_q + CNT_W'(1);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_ASSERT;
      timer_q    <= '0;
      filt_q     <= '0;
      pma_init_q <= 1'b1;
      reset_pb_q <= 1'b1;
      link_up_q  <= 1'b0;
      retry_q    <= '0;
      drop_q     <= '0;
    end else begin
      if (clear_counts) begin
        retry_q <= '0;
        drop_q  <= '0;
      end
      // A software reinit overrides whatever the FSM would otherwise do this cycle.
      if (reinit_req) begin
        state_q    <= ST_ASSERT;
        timer_q    <= '0;
        pma_init_q <= 1'b1;
        reset_pb_q <= 1'b1;
        link_up_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_ASSERT: begin
            if (timer_q == PMA_LAST) begin
              state_q    <= ST_PB_HOLD;
              timer_q    <= '0;
              pma_init_q <= 1'b0;
            end else begin
              timer_q <= timer_q + TMR_W'(1);
            end
          end
          ST_PB_HOLD: begin
            if (timer_q == PB_LAST) begin
              state_q    <= ST_WAIT_CH;
              timer_q    <= '0;
              reset_pb_q <= 1'b0;
            end else begin
              timer_q <= timer_q + TMR_W'(1);
            end
          end
          ST_WAIT_CH: begin
            if (ch_up) begin
              state_q   <= ST_UP;
              timer_q   <= '0;
              filt_q    <= '0;
              link_up_q <= 1'b1;
            end else if (timer_q == CTO_LAST) begin
              state_q    <= ST_ASSERT;
              timer_q    <= '0;
              pma_init_q <= 1'b1;
              reset_pb_q <= 1'b1;
              if (!clear_counts) retry_q <= retry_inc;
            end else begin
              timer_q <= timer_q + TMR_W'(1);
            end
          end
          ST_UP: begin
            if (c2c_link_error || (!ch_up && filt_q == FLT_LAST)) begin
              state_q   <= ST_DOWN;
              filt_q    <= '0;
              link_up_q <= 1'b0;
              if (!clear_counts) drop_q <= drop_inc;
            end else if (ch_up) begin
              filt_q <= '0;
            end else begin
              filt_q <= filt_q + FLT_W'(1);
            end
          end
          // ST_DOWN and the unused codes both restart the sequence.
          default: begin
            state_q    <= ST_ASSERT;
            timer_q    <= '0;
            pma_init_q <= 1'b1;
            reset_pb_q <= 1'b1;
            link_up_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign aurora_pma_init = pma_init_q;
  assign aurora_reset_pb = reset_pb_q;
  assign link_up         = link_up_q;
  assign state           = state_q;
  assign retry_count     = retry_q;
  assign drop_count      = drop_q;

endmodule

// File: tb/tb_c2c_master_link_ctrl.sv
// Randomised bench for c2c_master_link_ctrl: the driver plans expected output-change events
// (cycle stamp + output tuple) from the sequencing rules; a monitor pops them on every change.
module tb_c2c_master_link_ctrl;
  import c2c_pkg::*;

  localparam int unsigned PMA  = 8;
  localparam int unsigned PBH  = 4;
  localparam int unsigned CTO  = 32;
  localparam int unsigned DF   = 3;
  localparam int unsigned CW   = 2;
  localparam int          TUPW = 3 + 3 + 2 * CW;
  localparam int          EW   = 32 + TUPW;
  localparam int          CMAX = (1 << CW) - 1;

  // clock / reset and DUT signals
  logic          aclk             = 1'b0;
  logic          aresetn          = 1'b1;
  logic          channel_up_async = 1'b0;
  logic          c2c_link_error   = 1'b0;
  logic          reinit_req       = 1'b0;
  logic          clear_counts     = 1'b0;
  logic          aurora_pma_init;
  logic          aurora_reset_pb;
  logic          link_up;
  logic [2:0]    state;
  logic [CW-1:0] retry_count;
  logic [CW-1:0] drop_count;

  int            cyc    = 0;
  int            n_cmp  = 0;
  int            n_err  = 0;
  bit            mon_en = 1'b0;
  int            m_retry = 0;
  int            m_drop  = 0;
  logic [EW-1:0] exp_q[$];

  c2c_master_link_ctrl #(
    .PMA_INIT_CYCLES (PMA),
    .RESET_PB_HOLD   (PBH),
    .CHANNEL_TIMEOUT (CTO),
    .DROP_FILTER     (DF),
    .CNT_W           (CW)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .channel_up_async (channel_up_async),
    .c2c_link_error   (c2c_link_error),
    .reinit_req       (reinit_req),
    .clear_counts     (clear_counts),
    .aurora_pma_init  (aurora_pma_init),
    .aurora_reset_pb  (aurora_reset_pb),
    .link_up          (link_up),
    .state            (state),
    .retry_count      (retry_count),
    .drop_count       (drop_count)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  // reference model helpers
  function automatic int sat_inc(int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [EW-1:0] ev(int c, c2c_state_e st);
    logic pma, pb, lu;
    logic [31:0] cc;
    pma = (st == ST_ASSERT);
    pb  = (st == ST_ASSERT) || (st == ST_PB_HOLD);
    lu  = (st == ST_UP);
    cc  = c;
    return {cc, 3'(st), pma, pb, lu, CW'(m_retry), CW'(m_drop)};
  endfunction

  task automatic push(input int c, input c2c_state_e st);
    exp_q.push_back(ev(c, st));
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: each pushes the events it causes, then drives the stimulus
  task automatic bringup(input int a, output int w);
    push(a + PMA, ST_PB_HOLD);
    push(a + PMA + PBH, ST_WAIT_CH);
    w = a + PMA + PBH;
  endtask

  task automatic do_timeout(input int w, input bit clr, output int a);
    if (clr) begin
      m_retry = 0;
      m_drop  = 0;
    end else begin
      m_retry = sat_inc(m_retry);
    end
    push(w + CTO, ST_ASSERT);
    if (clr) begin
      wait_until(w + CTO - 1);
      clear_counts = 1'b1;
      step();
      clear_counts = 1'b0;
    end else begin
      wait_until(w + CTO);
    end
    a = w + CTO;
  endtask

  task automatic go_up(input int w, input int off, output int u);
    u = w + off + 3;
    push(u, ST_UP);
    wait_until(w + off);
    channel_up_async = 1'b1;
  endtask

  task automatic glitch(input int d, input int len);
    wait_until(d);
    channel_up_async = 1'b0;
    wait_until(d + len);
    channel_up_async = 1'b1;
  endtask

  task automatic do_drop(input int d, output int a);
    m_drop = sat_inc(m_drop);
    push(d + 2 + DF, ST_DOWN);
    push(d + 3 + DF, ST_ASSERT);
    wait_until(d);
    channel_up_async = 1'b0;
    a = d + 3 + DF;
  endtask

  task automatic do_err(input int e, output int a);
    m_drop = sat_inc(m_drop);
    push(e + 1, ST_DOWN);
    push(e + 2, ST_ASSERT);
    wait_until(e);
    c2c_link_error   = 1'b1;
    channel_up_async = 1'b0;
    step();
    c2c_link_error = 1'b0;
    a = e + 2;
  endtask

  task automatic do_reinit(input int e, input bit in_assert, output int a);
    if (!in_assert) push(e + 1, ST_ASSERT);
    wait_until(e);
    reinit_req       = 1'b1;
    channel_up_async = 1'b0;
    step();
    reinit_req = 1'b0;
    a = e + 1;
  endtask

  task automatic do_clear(input int e, input c2c_state_e st);
    if (m_retry != 0 || m_drop != 0) begin
      m_retry = 0;
      m_drop  = 0;
      push(e + 1, st);
    end
    wait_until(e);
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pma"},   32'(aurora_pma_init), 32'd1);
    check({tag, "_pb"},    32'(aurora_reset_pb), 32'd1);
    check({tag, "_link"},  32'(link_up), 32'd0);
    check({tag, "_state"}, 32'(state), 32'(ST_ASSERT));
    check({tag, "_retry"}, 32'(retry_count), 32'd0);
    check({tag, "_drop"},  32'(drop_count), 32'd0);
  endtask

  task automatic do_reset_mid(input int e, output int a);
    wait_until(e);
    m_retry = 0;
    m_drop  = 0;
    push(e, ST_ASSERT);
    aresetn          = 1'b0;
    channel_up_async = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) step();
    aresetn = 1'b1;
    a = cyc;
  endtask

  // scoreboard monitor: every change of the output tuple must match the next planned event
  initial begin : monitor
    logic [TUPW-1:0] prev_t;
    logic [TUPW-1:0] cur_t;
    logic [EW-1:0]   e;
    logic [31:0]     cc;
    prev_t = {3'(ST_ASSERT), 1'b1, 1'b1, 1'b0, CW'(0), CW'(0)};
    forever begin
      @(negedge aclk);
      if (mon_en) begin
        cur_t = {state, aurora_pma_init, aurora_reset_pb, link_up, retry_count, drop_count};
        if (cur_t !== prev_t) begin
          n_cmp++;
          cc = cyc;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL event: unplanned change at cyc %0d to tuple %0h", cyc, cur_t);
          end else begin
            e = exp_q.pop_front();
            if ({cc, cur_t} !== e) begin
              n_err++;
              $display("FAIL event: got cyc %0d tuple %0h expected cyc %0d tuple %0h",
                       cyc, cur_t, e[EW-1:TUPW], e[TUPW-1:0]);
            end
          end
          prev_t = cur_t;
        end
      end
    end
  end

  initial begin : driver
    int a, w, u, d, len;
    #1 aresetn = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (3) step();
    mon_en  = 1'b1;
    aresetn = 1'b1;
    a = cyc;

    // first attempt times out, retry_count becomes 1
    bringup(a, w);
    do_timeout(w, 1'b0, a);
    bringup(a, w);
    go_up(w, $urandom_range(0, 20), u);

    // short dropout is filtered, a long one is a drop
    len = $urandom_range(1, DF - 1);
    d = u + $urandom_range(0, 4);
    glitch(d, len);
    do_drop(d + len + 1 + $urandom_range(0, 4), a);

    // link error from UP, then reinit in WAIT_CH, coincident with timeout, in ASSERT, in UP
    bringup(a, w);
    go_up(w, $urandom_range(0, CTO - 3), u);
    do_err(u + $urandom_range(0, 6), a);
    bringup(a, w);
    do_reinit(w + $urandom_range(0, CTO - 2), 1'b0, a);
    bringup(a, w);
    do_reinit(w + CTO - 1, 1'b0, a);
    do_reinit(a + 3, 1'b1, a);
    bringup(a, w);
    go_up(w, CTO - 3, u);
    do_reinit(u + 2, 1'b0, a);

    // retry saturation and clear coincident with a timeout
    repeat (5) begin
      bringup(a, w);
      do_timeout(w, 1'b0, a);
    end
    bringup(a, w);
    do_timeout(w, 1'b1, a);

    // randomised mix
    repeat (10) begin
      bringup(a, w);
      case ($urandom_range(0, 3))
        0: do_timeout(w, ($urandom_range(0, 3) == 0), a);
        1: begin
          go_up(w, $urandom_range(0, CTO - 3), u);
          do_drop(u + $urandom_range(0, 5), a);
        end
        2: begin
          go_up(w, $urandom_range(0, CTO - 3), u);
          do_err(u + $urandom_range(0, 5), a);
        end
        default: begin
          do_clear(w + $urandom_range(0, 10), ST_WAIT_CH);
          do_timeout(w, 1'b0, a);
        end
      endcase
    end

    // asynchronous reset while UP, then a full restart
    bringup(a, w);
    go_up(w, $urandom_range(0, 20), u);
    do_reset_mid(u + $urandom_range(1, 5), a);
    bringup(a, w);
    do_timeout(w, 1'b0, a);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    step();
    check("drain_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/c2c_master_link_ctrl.md
Name: c2c_master_link_ctrl

Overview:
Bring-up and recovery sequencer for the master (initiator) end of the Aurora chip-to-chip link whose slave end sits on the VU13P.
- Drives the Aurora core's pma_init and reset_pb in the required order, then waits for channel_up.
- Asserts link_up to gate the AXI C2C master bridge.
- On timeout, link drop or error, re-runs the whole sequence and keeps saturating retry and drop statistics.

Parameters:
PMA_INIT_CYCLES, 1000, aclk cycles aurora_pma_init is held high per attempt (>=1)
RESET_PB_HOLD, 100, aclk cycles from pma_init release to reset_pb release (>=1)
CHANNEL_TIMEOUT, 1048576, aclk cycles to wait for channel_up before retrying (>=1)
DROP_FILTER, 16, consecutive aclk cycles of channel_up low that count as a link drop (>=1)
CNT_W, 8, width of retry_count and drop_count

Ports:
aclk  in  1  single clock; the Aurora init_clk domain
aresetn  in  1  asynchronous assert, active-low reset
channel_up_async  in  1  Aurora channel_up from user_clk domain; 2-flop synchronised internally
c2c_link_error  in  1  C2C master link error, synchronous to aclk, level
reinit_req  in  1  single-cycle software request to restart bring-up
clear_counts  in  1  single-cycle pulse that zeroes retry_count and drop_count
aurora_pma_init  out  1  to Aurora pma_init
aurora_reset_pb  out  1  to Aurora reset_pb
link_up  out  1  channel up and stable; releases the C2C bridge
state  out  3  encoded FSM state, for debug/ILA
retry_count  out  CNT_W  saturating count of CHANNEL_TIMEOUT expiries
drop_count  out  CNT_W  saturating count of link drops and errors from LINK_UP

Behaviour:
Reset values:
- aurora_pma_init=1, aurora_reset_pb=1, link_up=0, retry_count=0, drop_count=0.
- state=ASSERT (0), timer=0, synchroniser flops=0.

Synchroniser and outputs:
- ch_up = channel_up_async after 2 aclk flops.
- All outputs are registered.
- Timer width is $clog2 of the largest cycle parameter, plus 1.

States and encodings:
- ASSERT(0): pma_init=1, reset_pb=1. Timer counts. After exactly PMA_INIT_CYCLES cycles in ASSERT -> PB_HOLD, timer=0.
- PB_HOLD(1): pma_init=0, reset_pb=1. After RESET_PB_HOLD cycles -> WAIT_CH, timer=0.
- WAIT_CH(2): pma_init=0, reset_pb=0.
  - If ch_up=1 -> UP.
  - Else if timer reaches CHANNEL_TIMEOUT-1 -> ASSERT, retry_count+1.
  - ch_up and timeout in the same cycle: ch_up wins.
- UP(3): link_up=1.
  - Filter counter counts consecutive ch_up=0 cycles and clears on ch_up=1.
  - Filter reaches DROP_FILTER -> DOWN.
  - c2c_link_error=1 -> DOWN immediately.
- DOWN(4): link_up=0, drop_count+1. Next cycle -> ASSERT, timer=0.

Cycle-level timing:
- link_up rises in the first cycle of UP: 3 cycles after channel_up_async rises (2 sync + 1 register), provided the FSM is already in WAIT_CH.
- link_up falls in the first cycle of DOWN.
- aurora_pma_init rises together with entry into ASSERT.

reinit_req:
- Honoured in any state other than ASSERT: next state ASSERT, timer=0, link_up=0.
- Does not change any counter.
- In ASSERT it restarts the timer.
- Takes priority over every other transition in the same cycle.

Counters:
- Both saturate at 2^CNT_W-1; no wrap.
- clear_counts zeroes both counters next cycle.
- clear_counts coincident with an increment: clear wins, result 0.

Reset mid-operation:
- aresetn low in any state immediately forces all reset values, asynchronously.
- On deassertion the sequence starts from ASSERT with a full PMA_INIT_CYCLES hold.

Unused state codes 5-7 -> ASSERT.

Decomposition:
- Shared package c2c_pkg: state enum (ASSERT, PB_HOLD, WAIT_CH, UP, DOWN with the encodings above) and default timing constants, reused by the slave-side status block and by the bench.
- One sub-module: c2c_sync2, a 2-flop synchroniser with async active-low reset, reset value 0. It is instantiated for channel_up_async.
- FSM, timer, filter and counters stay in c2c_master_link_ctrl.

Test Plan:
Bench parameters for all scenarios: PMA_INIT_CYCLES=8, RESET_PB_HOLD=4, CHANNEL_TIMEOUT=32, DROP_FILTER=3, CNT_W=2.
1. Release aresetn, channel_up_async held 0 -> pma_init=1 for 8 cycles, then 0. reset_pb falls 4 cycles after pma_init falls. After 32 cycles in WAIT_CH, pma_init rises again and retry_count=1.
2. channel_up_async rises while in WAIT_CH -> link_up=1 exactly 3 cycles later, state=3, retry_count unchanged.
3. In UP, drop channel_up for 2 cycles then restore -> link_up stays 1. Drop for 3+ cycles -> link_up=0 in DOWN, drop_count=1, then state=0.
4. In UP, pulse c2c_link_error for 1 cycle -> DOWN next cycle, drop_count+1. Pulse reinit_req in WAIT_CH -> ASSERT with full 8-cycle hold, counters unchanged.
5. Force 5 timeouts -> retry_count saturates at 3. clear_counts coincident with a timeout -> retry_count=0.
6. Assert aresetn low while in UP -> link_up=0, pma_init=1, reset_pb=1 with no clock edge. Release -> full sequence restarts from ASSERT.
